// File: rtl/plb_master_arbiter_if.sv
// IPIF master command/status bundle between the arbiter (master) and the PLB
// master attachment (slave).
interface plb_master_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // Handshake: a Rd/Wr request is a valid that stays high, with address/BE/data
    // stable, until the cycle CmdAck (ready) is sampled; Cmplt closes the transfer.
    logic            IP2Bus_MstRd_Req;
    logic            IP2Bus_MstWr_Req;
    logic [AW-1:0]   IP2Bus_Mst_Addr;
    logic [DW/8-1:0] IP2Bus_Mst_BE;
    logic            IP2Bus_Mst_Lock;
    logic            IP2Bus_Mst_Reset;
    logic [DW-1:0]   IP2Bus_MstWr_d;

    logic            Bus2IP_Mst_CmdAck;
    logic            Bus2IP_Mst_Cmplt;
    logic            Bus2IP_Mst_Error;
    logic            Bus2IP_Mst_Rearbitrate;
    logic            Bus2IP_Mst_Cmd_Timeout;
    logic [DW-1:0]   Bus2IP_MstRd_d;
    logic            Bus2IP_MstRd_src_rdy_n;
    logic            Bus2IP_MstWr_dst_rdy_n;

    modport master (
        output IP2Bus_MstRd_Req, IP2Bus_MstWr_Req, IP2Bus_Mst_Addr, IP2Bus_Mst_BE,
               IP2Bus_Mst_Lock, IP2Bus_Mst_Reset, IP2Bus_MstWr_d,
        input  Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error,
               Bus2IP_Mst_Rearbitrate, Bus2IP_Mst_Cmd_Timeout, Bus2IP_MstRd_d,
               Bus2IP_MstRd_src_rdy_n, Bus2IP_MstWr_dst_rdy_n
    );

    modport slave (
        input  IP2Bus_MstRd_Req, IP2Bus_MstWr_Req, IP2Bus_Mst_Addr, IP2Bus_Mst_BE,
               IP2Bus_Mst_Lock, IP2Bus_Mst_Reset, IP2Bus_MstWr_d,
        output Bus2IP_Mst_CmdAck, Bus2IP_Mst_Cmplt, Bus2IP_Mst_Error,
               Bus2IP_Mst_Rearbitrate, Bus2IP_Mst_Cmd_Timeout, Bus2IP_MstRd_d,
               Bus2IP_MstRd_src_rdy_n, Bus2IP_MstWr_dst_rdy_n
    );
endinterface

// File: rtl/plb_master_arbiter.sv
// Round-robin sharing of one IPIF master port between two single-beat requesters,
// with Rearbitrate back-off and a watchdog that aborts hung transfers.
module plb_master_arbiter #(
    parameter int C_MST_AWIDTH   = 32,
    parameter int C_MST_DWIDTH   = 32,
    parameter int BACKOFF_CYCLES = 4,
    parameter int WDOG_CYCLES    = 1024,
    parameter int WDOG_W         = 11
) (
    input  logic                      PLB_clk,
    input  logic                      reset,

    input  logic                      r0_req,
    input  logic                      r0_rnw,
    input  logic [C_MST_AWIDTH-1:0]   r0_addr,
    input  logic [C_MST_DWIDTH/8-1:0] r0_be,
    input  logic [C_MST_DWIDTH-1:0]   r0_wr_d,
    output logic                      r0_done,
    output logic                      r0_err,
    output logic [C_MST_DWIDTH-1:0]   r0_rd_d,

    input  logic                      r1_req,
    input  logic                      r1_rnw,
    input  logic [C_MST_AWIDTH-1:0]   r1_addr,
    input  logic [C_MST_DWIDTH/8-1:0] r1_be,
    input  logic [C_MST_DWIDTH-1:0]   r1_wr_d,
    output logic                      r1_done,
    output logic                      r1_err,
    output logic [C_MST_DWIDTH-1:0]   r1_rd_d,

    output logic [1:0]                grant,
    output logic [2:0]                state,

    plb_master_arbiter_if.master      bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_DATA    = 3'd2,
        S_BACKOFF = 3'd3,
        S_ABORT   = 3'd4
    } state_t;

    localparam int BO_W = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES) : 1;

    state_t                  st;
    logic                    owner;    // 1 = r1 holds the grant
    logic                    rr_ptr;   // requester that wins a tie
    logic                    rnw_q;
    logic [WDOG_W-1:0]       wdog;
    logic [BO_W-1:0]         bo_cnt;
    logic [C_MST_DWIDTH-1:0] rd_buf;

    logic                    pick1;
    logic                    sel_rnw;
    logic                    fin;
    logic                    fin_err;
    logic                    expire;
    logic [C_MST_DWIDTH-1:0] cap_d;

    assign state               = st;
    assign bus.IP2Bus_Mst_Lock = 1'b0;
    assign pick1   = r1_req && (!r0_req || rr_ptr);
    assign sel_rnw = pick1 ? r1_rnw : r0_rnw;

    logic unused_ok;
    assign unused_ok = &{1'b0, bus.Bus2IP_MstWr_dst_rdy_n};

    always_comb begin
        fin     = 1'b0;
        fin_err = 1'b0;
        cap_d   = rd_buf;
        // A beat arriving on the completing cycle must still reach the requester.
        if (rnw_q && !bus.Bus2IP_MstRd_src_rdy_n)
            cap_d = bus.Bus2IP_MstRd_d;
        case (st)
            S_REQ: begin
                if (bus.Bus2IP_Mst_Cmd_Timeout) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end else if (bus.Bus2IP_Mst_CmdAck && bus.Bus2IP_Mst_Cmplt) begin
                    fin     = 1'b1;
                    fin_err = bus.Bus2IP_Mst_Error;
                end
            end
            S_DATA: begin
                if (bus.Bus2IP_Mst_Cmplt) begin
                    fin     = 1'b1;
                    fin_err = bus.Bus2IP_Mst_Error;
                end
            end
            S_ABORT: begin
                fin     = 1'b1;
                fin_err = 1'b1;
            end
            default: ;
        endcase
        expire = (st == S_REQ || st == S_DATA || st == S_BACKOFF) &&
                 (wdog == WDOG_W'(1)) && !fin;
    end

    always_ff @(posedge PLB_clk or posedge reset) begin
        if (reset) begin
            st                   <= S_IDLE;
            owner                <= 1'b0;
            rr_ptr               <= 1'b0;
            rnw_q                <= 1'b0;
            wdog                 <= '0;
            bo_cnt               <= '0;
            rd_buf               <= '0;
            grant                <= 2'b00;
            r0_done              <= 1'b0;
            r0_err               <= 1'b0;
            r0_rd_d              <= '0;
            r1_done              <= 1'b0;
            r1_err               <= 1'b0;
            r1_rd_d              <= '0;
            bus.IP2Bus_MstRd_Req <= 1'b0;
            bus.IP2Bus_MstWr_Req <= 1'b0;
            bus.IP2Bus_Mst_Addr  <= '0;
            bus.IP2Bus_Mst_BE    <= '0;
            bus.IP2Bus_Mst_Reset <= 1'b0;
            bus.IP2Bus_MstWr_d   <= '0;
        end else begin
            r0_done              <= 1'b0;
            r1_done              <= 1'b0;
            bus.IP2Bus_Mst_Reset <= 1'b0;
            if (fin) begin
                if (owner) begin
                    r1_done <= 1'b1;
                    r1_err  <= fin_err;
                    r1_rd_d <= cap_d;
                end else begin
                    r0_done <= 1'b1;
                    r0_err  <= fin_err;
                    r0_rd_d <= cap_d;
                end
                rr_ptr               <= ~owner;
                grant                <= 2'b00;
                bus.IP2Bus_MstRd_Req <= 1'b0;
                bus.IP2Bus_MstWr_Req <= 1'b0;
                st                   <= S_IDLE;
            end else if (expire) begin
                bus.IP2Bus_MstRd_Req <= 1'b0;
                bus.IP2Bus_MstWr_Req <= 1'b0;
                bus.IP2Bus_Mst_Reset <= 1'b1;
                st                   <= S_ABORT;
            end else begin
                case (st)
                    S_IDLE: begin
                        if (r0_req || r1_req) begin
                            owner                <= pick1;
                            grant                <= pick1 ? 2'b10 : 2'b01;
                            rnw_q                <= sel_rnw;
                            bus.IP2Bus_Mst_Addr  <= pick1 ? r1_addr : r0_addr;
                            bus.IP2Bus_Mst_BE    <= pick1 ? r1_be : r0_be;
                            bus.IP2Bus_MstWr_d   <= pick1 ? r1_wr_d : r0_wr_d;
                            bus.IP2Bus_MstRd_Req <= sel_rnw;
                            bus.IP2Bus_MstWr_Req <= !sel_rnw;
                            wdog                 <= WDOG_W'(WDOG_CYCLES);
                            rd_buf               <= '0;
                            st                   <= S_REQ;
                        end
                    end
                    S_REQ: begin
                        wdog <= wdog - WDOG_W'(1);
                        if (bus.Bus2IP_Mst_CmdAck) begin
                            bus.IP2Bus_MstRd_Req <= 1'b0;
                            bus.IP2Bus_MstWr_Req <= 1'b0;
                            st                   <= S_DATA;
                        end else if (bus.Bus2IP_Mst_Rearbitrate) begin
                            bus.IP2Bus_MstRd_Req <= 1'b0;
                            bus.IP2Bus_MstWr_Req <= 1'b0;
                            bo_cnt               <= BO_W'(BACKOFF_CYCLES - 1);
                            st                   <= S_BACKOFF;
                        end
                    end
                    S_BACKOFF: begin
                        wdog <= wdog - WDOG_W'(1);
                        // Re-issue on the last idle cycle's edge so Req stays low exactly BACKOFF_CYCLES.
                        if (bo_cnt == '0) begin
                            bus.IP2Bus_MstRd_Req <= rnw_q;
                            bus.IP2Bus_MstWr_Req <= !rnw_q;
                            st                   <= S_REQ;
                        end else begin
                            bo_cnt <= bo_cnt - BO_W'(1);
                        end
                    end
                    S_DATA: begin
                        wdog <= wdog - WDOG_W'(1);
                        if (rnw_q && !bus.Bus2IP_MstRd_src_rdy_n)
                            rd_buf <= bus.Bus2IP_MstRd_d;
                    end
                    default: st <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_plb_master_arbiter.sv
// Scenario bench for plb_master_arbiter: a scripted IPIF slave, a done-pulse
// scoreboard fed from an expected queue, and per-scenario inline checks.
module tb_plb_master_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_REQ     = 3'd1;
    localparam logic [2:0] ST_DATA    = 3'd2;
    localparam logic [2:0] ST_BACKOFF = 3'd3;
    localparam logic [2:0] ST_ABORT   = 3'd4;

    logic          PLB_clk;
    logic          reset;
    logic          r0_req, r0_rnw, r0_done, r0_err;
    logic [AW-1:0] r0_addr;
    logic [3:0]    r0_be;
    logic [DW-1:0] r0_wr_d, r0_rd_d;
    logic          r1_req, r1_rnw, r1_done, r1_err;
    logic [AW-1:0] r1_addr;
    logic [3:0]    r1_be;
    logic [DW-1:0] r1_wr_d, r1_rd_d;
    logic [1:0]    grant;
    logic [2:0]    state;

    plb_master_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    plb_master_arbiter #(
        .C_MST_AWIDTH(AW), .C_MST_DWIDTH(DW), .BACKOFF_CYCLES(4),
        .WDOG_CYCLES(16), .WDOG_W(11)
    ) dut (
        .PLB_clk(PLB_clk), .reset(reset),
        .r0_req(r0_req), .r0_rnw(r0_rnw), .r0_addr(r0_addr), .r0_be(r0_be),
        .r0_wr_d(r0_wr_d), .r0_done(r0_done), .r0_err(r0_err), .r0_rd_d(r0_rd_d),
        .r1_req(r1_req), .r1_rnw(r1_rnw), .r1_addr(r1_addr), .r1_be(r1_be),
        .r1_wr_d(r1_wr_d), .r1_done(r1_done), .r1_err(r1_err), .r1_rd_d(r1_rd_d),
        .grant(grant), .state(state), .bus(bus)
    );

    // clock / reset
    initial PLB_clk = 1'b0;
    always #5 PLB_clk = ~PLB_clk;

    int n_chk  = 0;
    int n_pass = 0;

    // {id, rnw, err, rd_d}
    logic [34:0] exp_q[$];
    logic [34:0] mon_e;
    logic        mon_err;
    logic [31:0] mon_d;
    int          wr_req_cycles;
    bit          saw_data;

    always @(negedge PLB_clk) begin
        if (bus.IP2Bus_MstWr_Req === 1'b1) wr_req_cycles++;
        if (state === ST_DATA) saw_data = 1'b1;
        if (r0_done === 1'b1 || r1_done === 1'b1) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                $display("FAIL done_unexpected r0_done=%b r1_done=%b expected no done", r0_done, r1_done);
            end else begin
                mon_e   = exp_q.pop_front();
                mon_err = r1_done ? r1_err : r0_err;
                mon_d   = r1_done ? r1_rd_d : r0_rd_d;
                if ((r0_done && r1_done) || r1_done !== mon_e[34] || mon_err !== mon_e[32] ||
                    (mon_e[33] && mon_d !== mon_e[31:0]))
                    $display("FAIL done_scoreboard got id=%b err=%b d=%h both=%b exp id=%b err=%b d=%h",
                             r1_done, mon_err, mon_d, r0_done && r1_done, mon_e[34], mon_e[32], mon_e[31:0]);
                else
                    n_pass++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    // driver tasks
    task automatic tick;
        @(negedge PLB_clk);
    endtask

    task automatic bus_idle;
        bus.Bus2IP_Mst_CmdAck      = 1'b0;
        bus.Bus2IP_Mst_Cmplt       = 1'b0;
        bus.Bus2IP_Mst_Error       = 1'b0;
        bus.Bus2IP_Mst_Rearbitrate = 1'b0;
        bus.Bus2IP_Mst_Cmd_Timeout = 1'b0;
        bus.Bus2IP_MstRd_d         = 32'h0;
        bus.Bus2IP_MstRd_src_rdy_n = 1'b1;
        bus.Bus2IP_MstWr_dst_rdy_n = 1'b0;
    endtask

    // Slave: ack after ack_dly cycles of Req; Cmplt cmp_dly cycles after ack
    // (0 = same cycle). Read data is offered the cycle before Cmplt when possible.
    task automatic serve(input int ack_dly, input int cmp_dly, input logic [31:0] rd, input logic er);
        int n;
        n = 0;
        while (!(bus.IP2Bus_MstRd_Req || bus.IP2Bus_MstWr_Req) && n < 50) begin
            tick;
            n++;
        end
        if (n >= 50) begin
            n_chk++;
            $display("FAIL serve_req_wait got no request within %0d cycles, required a request", n);
        end
        repeat (ack_dly) tick;
        bus.Bus2IP_Mst_CmdAck = 1'b1;
        if (cmp_dly == 0) begin
            bus.Bus2IP_Mst_Cmplt       = 1'b1;
            bus.Bus2IP_Mst_Error       = er;
            bus.Bus2IP_MstRd_src_rdy_n = 1'b0;
            bus.Bus2IP_MstRd_d         = rd;
        end
        tick;
        bus_idle;
        if (cmp_dly == 1) begin
            bus.Bus2IP_MstRd_src_rdy_n = 1'b0;
            bus.Bus2IP_MstRd_d         = rd;
            bus.Bus2IP_Mst_Cmplt       = 1'b1;
            bus.Bus2IP_Mst_Error       = er;
            tick;
            bus_idle;
        end else if (cmp_dly >= 2) begin
            repeat (cmp_dly - 2) tick;
            bus.Bus2IP_MstRd_src_rdy_n = 1'b0;
            bus.Bus2IP_MstRd_d         = rd;
            tick;
            bus.Bus2IP_MstRd_src_rdy_n = 1'b1;
            bus.Bus2IP_MstRd_d         = 32'hDEAD_BEEF;
            bus.Bus2IP_Mst_Cmplt       = 1'b1;
            bus.Bus2IP_Mst_Error       = er;
            tick;
            bus_idle;
        end
    endtask

    // scenarios
    task automatic test_reset;
        reset = 1'b1;
        r0_req = 0; r0_rnw = 0; r0_addr = '0; r0_be = '0; r0_wr_d = '0;
        r1_req = 0; r1_rnw = 0; r1_addr = '0; r1_be = '0; r1_wr_d = '0;
        bus_idle;
        repeat (3) tick;
        n_chk++;
        if ({grant, state} !== 5'b0) $display("FAIL reset_grant_state got grant=%b state=%0d required 00/0", grant, state);
        else n_pass++;
        n_chk++;
        if ({bus.IP2Bus_MstRd_Req, bus.IP2Bus_MstWr_Req, bus.IP2Bus_Mst_Reset, bus.IP2Bus_Mst_Lock,
             r0_done, r0_err, r1_done, r1_err} !== 8'b0)
            $display("FAIL reset_ctrl got rd=%b wr=%b rst=%b lock=%b d0=%b e0=%b d1=%b e1=%b required all 0",
                     bus.IP2Bus_MstRd_Req, bus.IP2Bus_MstWr_Req, bus.IP2Bus_Mst_Reset, bus.IP2Bus_Mst_Lock,
                     r0_done, r0_err, r1_done, r1_err);
        else n_pass++;
        n_chk++;
        if ({bus.IP2Bus_Mst_Addr, bus.IP2Bus_MstWr_d, r0_rd_d, r1_rd_d} !== 128'b0)
            $display("FAIL reset_data got addr=%h wd=%h rd0=%h rd1=%h required 0",
                     bus.IP2Bus_Mst_Addr, bus.IP2Bus_MstWr_d, r0_rd_d, r1_rd_d);
        else n_pass++;
        reset = 1'b0;
        tick;
    endtask

    task automatic test_single_write;
        r0_rnw = 0; r0_addr = 32'h9000_0100; r0_be = 4'hF; r0_wr_d = 32'hFF00_FF00;
        r0_req = 1;
        exp_q.push_back({1'b0, 1'b0, 1'b0, 32'h0});
        wr_req_cycles = 0;
        tick;
        n_chk++;
        if (grant !== 2'b01 || state !== ST_REQ) $display("FAIL wr_grant got grant=%b state=%0d required 01/1", grant, state);
        else n_pass++;
        n_chk++;
        if (bus.IP2Bus_MstWr_Req !== 1'b1 || bus.IP2Bus_MstRd_Req !== 1'b0)
            $display("FAIL wr_req got wr=%b rd=%b required 1/0", bus.IP2Bus_MstWr_Req, bus.IP2Bus_MstRd_Req);
        else n_pass++;
        n_chk++;
        if (bus.IP2Bus_Mst_Addr !== 32'h9000_0100 || bus.IP2Bus_MstWr_d !== 32'hFF00_FF00 || bus.IP2Bus_Mst_BE !== 4'hF)
            $display("FAIL wr_cmd got addr=%h d=%h be=%h required 90000100/ff00ff00/f",
                     bus.IP2Bus_Mst_Addr, bus.IP2Bus_MstWr_d, bus.IP2Bus_Mst_BE);
        else n_pass++;
        r0_addr = 32'h0; r0_wr_d = 32'h0;
        serve(2, 2, 32'h0, 1'b0);
        n_chk++;
        if (r0_done !== 1'b1 || grant !== 2'b00 || state !== ST_IDLE)
            $display("FAIL wr_done got done=%b grant=%b state=%0d required 1/00/0", r0_done, grant, state);
        else n_pass++;
        n_chk++;
        if (bus.IP2Bus_Mst_Addr !== 32'h9000_0100 || bus.IP2Bus_MstWr_d !== 32'hFF00_FF00)
            $display("FAIL wr_latched got addr=%h d=%h required 90000100/ff00ff00", bus.IP2Bus_Mst_Addr, bus.IP2Bus_MstWr_d);
        else n_pass++;
        n_chk++;
        if (wr_req_cycles < 1 || wr_req_cycles > 3) $display("FAIL wr_req_len got %0d cycles required 1..3", wr_req_cycles);
        else n_pass++;
        r0_req = 0;
        tick;
        n_chk++;
        if (r0_done !== 1'b0 || grant !== 2'b00) $display("FAIL wr_pulse got done=%b grant=%b required 0/00", r0_done, grant);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [31:0] rdv[4];
        int n;
        reset = 1'b1; tick; reset = 1'b0; tick;
        r0_rnw = 0; r0_addr = 32'h9000_0400; r0_be = 4'h3; r0_wr_d = 32'hA5A5_0001;
        r1_rnw = 1; r1_addr = 32'h9000_0800; r1_be = 4'hF; r1_wr_d = 32'h0;
        for (int i = 0; i < 4; i++) begin
            rdv[i] = $urandom;
            if (i % 2 == 0) exp_q.push_back({1'b0, 1'b0, 1'b0, 32'h0});
            else            exp_q.push_back({1'b1, 1'b1, 1'b0, rdv[i]});
        end
        r0_req = 1; r1_req = 1;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (grant === 2'b00 && n < 10) begin tick; n++; end
            n_chk++;
            if (grant !== ((i % 2 == 1) ? 2'b10 : 2'b01))
                $display("FAIL b2b_grant txn=%0d got %b required %b", i, grant, (i % 2 == 1) ? 2'b10 : 2'b01);
            else n_pass++;
            serve($urandom_range(0, 2), $urandom_range(1, 3), rdv[i], 1'b0);
            n_chk++;
            if (grant !== 2'b00 || state !== ST_IDLE)
                $display("FAIL b2b_idle_gap txn=%0d got grant=%b state=%0d required 00/0", i, grant, state);
            else n_pass++;
            if (i == 3) begin r0_req = 0; r1_req = 0; end
        end
        tick;
        n_chk++;
        if (grant !== 2'b00) $display("FAIL b2b_end got grant=%b required 00", grant);
        else n_pass++;
    endtask

    task automatic test_rearbitrate;
        int n;
        r1_rnw = 1; r1_addr = 32'h9000_0200; r1_be = 4'hF;
        r1_req = 1;
        exp_q.push_back({1'b1, 1'b1, 1'b0, 32'h1234_5678});
        tick;
        n_chk++;
        if (grant !== 2'b10 || bus.IP2Bus_MstRd_Req !== 1'b1)
            $display("FAIL rearb_first got grant=%b rd=%b required 10/1", grant, bus.IP2Bus_MstRd_Req);
        else n_pass++;
        bus.Bus2IP_Mst_Rearbitrate = 1'b1;
        tick;
        bus.Bus2IP_Mst_Rearbitrate = 1'b0;
        n_chk++;
        if (state !== ST_BACKOFF || bus.IP2Bus_MstRd_Req !== 1'b0)
            $display("FAIL rearb_backoff got state=%0d rd=%b required 3/0", state, bus.IP2Bus_MstRd_Req);
        else n_pass++;
        n = 0;
        while (bus.IP2Bus_MstRd_Req !== 1'b1 && n < 20) begin n++; tick; end
        n_chk++;
        if (n !== 4) $display("FAIL backoff_len got %0d cycles low required 4", n);
        else n_pass++;
        n_chk++;
        if (bus.IP2Bus_Mst_Addr !== 32'h9000_0200 || grant !== 2'b10 || state !== ST_REQ)
            $display("FAIL rearb_retry got addr=%h grant=%b state=%0d required 90000200/10/1",
                     bus.IP2Bus_Mst_Addr, grant, state);
        else n_pass++;
        serve(1, 2, 32'h1234_5678, 1'b0);
        n_chk++;
        if (r1_done !== 1'b1 || r1_rd_d !== 32'h1234_5678)
            $display("FAIL rearb_rd_d got done=%b d=%h required 1/12345678", r1_done, r1_rd_d);
        else n_pass++;
        r1_req = 0;
        tick;
    endtask

    task automatic test_watchdog;
        int n;
        r0_rnw = 0; r0_addr = 32'h9000_0300; r0_be = 4'hF; r0_wr_d = 32'h0BAD_F00D;
        r0_req = 1;
        exp_q.push_back({1'b0, 1'b0, 1'b1, 32'h0});
        tick;
        bus.Bus2IP_Mst_CmdAck = 1'b1;
        tick;
        bus.Bus2IP_Mst_CmdAck = 1'b0;
        n = 1;
        while (state !== ST_ABORT && n < 40) begin tick; n++; end
        n_chk++;
        if (n !== 16) $display("FAIL wdog_len got abort after %0d cycles required 16", n);
        else n_pass++;
        n_chk++;
        if (bus.IP2Bus_Mst_Reset !== 1'b1 || bus.IP2Bus_MstWr_Req !== 1'b0 || bus.IP2Bus_MstRd_Req !== 1'b0)
            $display("FAIL wdog_mst_reset got rst=%b wr=%b rd=%b required 1/0/0",
                     bus.IP2Bus_Mst_Reset, bus.IP2Bus_MstWr_Req, bus.IP2Bus_MstRd_Req);
        else n_pass++;
        tick;
        n_chk++;
        if (bus.IP2Bus_Mst_Reset !== 1'b0 || state !== ST_IDLE || r0_done !== 1'b1 || r0_err !== 1'b1)
            $display("FAIL wdog_after got rst=%b state=%0d done=%b err=%b required 0/0/1/1",
                     bus.IP2Bus_Mst_Reset, state, r0_done, r0_err);
        else n_pass++;
        r0_req = 0;
        tick;
    endtask

    task automatic test_errors;
        logic [31:0] rd;
        // Cmd_Timeout while requesting
        r0_rnw = 0; r0_addr = 32'h9000_0500; r0_req = 1;
        exp_q.push_back({1'b0, 1'b0, 1'b1, 32'h0});
        tick;
        bus.Bus2IP_Mst_Cmd_Timeout = 1'b1;
        tick;
        bus.Bus2IP_Mst_Cmd_Timeout = 1'b0;
        n_chk++;
        if (state !== ST_IDLE || r0_done !== 1'b1 || r0_err !== 1'b1 || bus.IP2Bus_MstWr_Req !== 1'b0)
            $display("FAIL tmo_done got state=%0d done=%b err=%b wr=%b required 0/1/1/0",
                     state, r0_done, r0_err, bus.IP2Bus_MstWr_Req);
        else n_pass++;
        r0_req = 0;
        tick;
        // Cmplt carrying Error
        r0_req = 1;
        exp_q.push_back({1'b0, 1'b0, 1'b1, 32'h0});
        tick;
        serve(1, 1, 32'h0, 1'b1);
        r0_req = 0;
        tick;
        // CmdAck and Cmplt together skip DATA
        rd = $urandom;
        r1_rnw = 1; r1_addr = 32'h9000_0600; r1_req = 1;
        exp_q.push_back({1'b1, 1'b1, 1'b0, rd});
        saw_data = 1'b0;
        tick;
        serve(1, 0, rd, 1'b0);
        n_chk++;
        if (saw_data !== 1'b0 || state !== ST_IDLE || r1_done !== 1'b1)
            $display("FAIL ack_cmplt got saw_data=%b state=%0d done=%b required 0/0/1", saw_data, state, r1_done);
        else n_pass++;
        r1_req = 0;
        tick;
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd;
        r0_rnw = 0; r0_addr = 32'h9000_0700; r0_req = 1;
        tick;
        bus.Bus2IP_Mst_CmdAck = 1'b1;
        tick;
        bus.Bus2IP_Mst_CmdAck = 1'b0;
        n_chk++;
        if (state !== ST_DATA) $display("FAIL rstmid_pre got state=%0d required 2", state);
        else n_pass++;
        #1 reset = 1'b1;
        #1;
        n_chk++;
        if (state !== ST_IDLE || grant !== 2'b00 || bus.IP2Bus_MstWr_Req !== 1'b0 || r0_done !== 1'b0)
            $display("FAIL rstmid_async got state=%0d grant=%b wr=%b done=%b required 0/00/0/0",
                     state, grant, bus.IP2Bus_MstWr_Req, r0_done);
        else n_pass++;
        r0_req = 0;
        repeat (2) tick;
        reset = 1'b0;
        tick;
        n_chk++;
        if (r0_done !== 1'b0 || state !== ST_IDLE) $display("FAIL rstmid_nodone got done=%b state=%0d required 0/0", r0_done, state);
        else n_pass++;
        rd = $urandom;
        r1_rnw = 1; r1_addr = 32'h9000_0900; r1_req = 1;
        exp_q.push_back({1'b1, 1'b1, 1'b0, rd});
        tick;
        n_chk++;
        if (grant !== 2'b10) $display("FAIL rstmid_regrant got grant=%b required 10", grant);
        else n_pass++;
        serve(1, 1, rd, 1'b0);
        r1_req = 0;
        tick;
    endtask

    // report
    initial begin
        test_reset;
        test_single_write;
        test_back_to_back;
        test_rearbitrate;
        test_watchdog;
        test_errors;
        test_reset_mid;
        repeat (3) tick;
        n_chk++;
        if (exp_q.size() != 0) $display("FAIL scoreboard_drain got %0d entries left required 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
